// File: rtl/shared_stage_pkg.sv
// Shared types for the two-requester shared-stage arbiter: FSM encoding,
// source tag type and the lock-beat counter width.
package shared_stage_pkg;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  typedef logic src_t;

  function automatic arb_state_e grant_of(input src_t n);
    return n ? GRANT1 : GRANT0;
  endfunction

  // Fresh arbitration: a lone requester wins outright, a tie goes to pref.
  function automatic arb_state_e arbitrate(input logic v0, input logic v1, input src_t pref);
    if (v0 && v1) return grant_of(pref);
    if (v0)       return GRANT0;
    if (v1)       return GRANT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/stage_slot.sv
// Single-entry output register holding {src, data}; loads on an accept,
// empties on a downstream handshake, and holds under backpressure.
module stage_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_src_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_src_o,
  output logic             slot_free_o
);

  logic           valid_q, valid_d;
  logic [WIDTH:0] word_q,  word_d;

  // A load wins over a drain: that is the back-to-back full-throughput case.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = {load_src_i, load_data_i};
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = word_q[WIDTH-1:0];
  assign out_src_o   = word_q[WIDTH];
  assign slot_free_o = !valid_q || out_ready_i;

endmodule

// File: rtl/shared_stage_arb.sv
// Round-robin arbiter for two valid/ready producers sharing one registered
// output stage, with a grant that holds for LOCK_BEATS accepted beats.
module shared_stage_arb #(
  parameter int WIDTH      = 8,
  parameter int LOCK_BEATS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  import shared_stage_pkg::*;

  // Handshake: a word moves when valid and ready are both high at a rising
  // edge; producers hold valid/data until accepted, consumer ready is free.

  localparam logic [BEAT_CNT_W-1:0] LOCK_LAST = BEAT_CNT_W'(LOCK_BEATS - 1);
  localparam logic [BEAT_CNT_W-1:0] CNT_ONE   = BEAT_CNT_W'(1);

  arb_state_e            state_q, state_d;
  src_t                  rr_q, rr_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

  logic slot_free;
  logic accept0, accept1, accept;
  src_t cur, oth;
  logic cur_valid, oth_valid, last_beat;

  assign accept0   = req0_valid && req0_ready;
  assign accept1   = req1_valid && req1_ready;
  assign accept    = accept0 || accept1;
  assign cur       = (state_q == GRANT1);
  assign oth       = ~cur;
  assign cur_valid = cur ? req1_valid : req0_valid;
  assign oth_valid = cur ? req0_valid : req1_valid;
  assign last_beat = (cnt_q == LOCK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = arbitrate(req0_valid, req1_valid, rr_q);
      GRANT0, GRANT1: begin
        if (accept) begin
          if (last_beat && oth_valid) begin
            state_d = grant_of(oth);
            rr_d    = oth;
            cnt_d   = '0;
          end else if (cur_valid) begin
            cnt_d = last_beat ? '0 : cnt_q + CNT_ONE;
          end else if (oth_valid) begin
            state_d = grant_of(oth);
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (!cur_valid) begin
          // Granted requester withdrew: the other side gets first look.
          state_d = oth_valid ? grant_of(oth) : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Readies are forced low while reset is asserted so no handshake completes.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      req0_ready = (state_q == GRANT0) && slot_free;
      req1_ready = (state_q == GRANT1) && slot_free;
    end
    busy = (state_q != IDLE) || out_valid;
  end

  assign dbg_state_o = state_q;

  stage_slot #(.WIDTH(WIDTH)) u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i (accept1 ? req1_data : req0_data),
    .load_src_i  (accept1),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .slot_free_o (slot_free)
  );

endmodule

// File: tb/tb_shared_stage_arb.sv
// Bench for shared_stage_arb: one instance with LOCK_BEATS=1 and one with
// LOCK_BEATS=3, selected in turn, checked against an expected-word queue.
module tb_shared_stage_arb;

  import shared_stage_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus, muxed per instance ----------------
  logic         sel = 1'b0;  // 0: LOCK_BEATS=1 instance, 1: LOCK_BEATS=3
  logic         req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] req0_data = '0, req1_data = '0;

  logic         a_r0r, a_r1r, a_ov, a_os, a_busy;
  logic [W-1:0] a_od;
  logic [1:0]   a_st;
  logic         b_r0r, b_r1r, b_ov, b_os, b_busy;
  logic [W-1:0] b_od;
  logic [1:0]   b_st;

  logic         req0_ready, req1_ready, out_valid, out_src, busy;
  logic [W-1:0] out_data;
  logic [1:0]   dbg_state;

  assign req0_ready = sel ? b_r0r  : a_r0r;
  assign req1_ready = sel ? b_r1r  : a_r1r;
  assign out_valid  = sel ? b_ov   : a_ov;
  assign out_data   = sel ? b_od   : a_od;
  assign out_src    = sel ? b_os   : a_os;
  assign busy       = sel ? b_busy : a_busy;
  assign dbg_state  = sel ? b_st   : a_st;

  shared_stage_arb #(.WIDTH(W), .LOCK_BEATS(1)) u_lock1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid && !sel), .req0_data(req0_data), .req0_ready(a_r0r),
    .req1_valid(req1_valid && !sel), .req1_data(req1_data), .req1_ready(a_r1r),
    .out_valid(a_ov), .out_data(a_od), .out_src(a_os),
    .out_ready(sel ? 1'b1 : out_ready), .busy(a_busy), .dbg_state_o(a_st)
  );

  shared_stage_arb #(.WIDTH(W), .LOCK_BEATS(3)) u_lock3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid && sel), .req0_data(req0_data), .req0_ready(b_r0r),
    .req1_valid(req1_valid && sel), .req1_data(req1_data), .req1_ready(b_r1r),
    .out_valid(b_ov), .out_data(b_od), .out_src(b_os),
    .out_ready(sel ? out_ready : 1'b1), .busy(b_busy), .dbg_state_o(b_st)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] p0_q[$];
  logic [W-1:0] p1_q[$];
  logic [W:0]   exp_q[$];   // {src, data}
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_word(input logic src, input logic [W-1:0] data);
    exp_q.push_back({src, data});
  endtask

  // ---------------- driver / monitor ----------------
  task automatic drive();
    req0_valid = (p0_q.size() != 0);
    req0_data  = req0_valid ? p0_q[0] : '0;
    req1_valid = (p1_q.size() != 0);
    req1_data  = req1_valid ? p1_q[0] : '0;
  endtask

  // Runs at the falling edge: inputs are settled, so these handshakes are
  // exactly the ones the next rising edge will complete.
  task automatic monitor();
    logic [W:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {23'd0, out_src, out_data}, 32'hdead);
      end else begin
        e = exp_q.pop_front();
        check("out_word", {23'd0, out_src, out_data}, {23'd0, e});
      end
    end
    if (rst_n && req0_valid && req0_ready) void'(p0_q.pop_front());
    if (rst_n && req1_valid && req1_ready) void'(p1_q.pop_front());
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((exp_q.size() != 0 || p0_q.size() != 0 || p1_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic settle_idle(input string tag);
    cycle();
    cycle();
    check({tag, "_idle_state"}, dbg_state, IDLE);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    #1;

    // Reset held for two edges with requester 0 already valid.
    p0_q.push_back(8'h11); p0_q.push_back(8'h22); p0_q.push_back(8'h33);
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_lock3_state", b_st, IDLE);

    // Single requester, full throughput: outputs on cycles 2, 3, 4.
    rst_n = 1'b1;
    expect_word(1'b0, 8'h11); expect_word(1'b0, 8'h22); expect_word(1'b0, 8'h33);
    drive();
    check("c0_ready0", req0_ready, 0);
    cycle();
    check("c1_state", dbg_state, GRANT0);
    check("c1_ready0", req0_ready, 1);
    check("c1_out_valid", out_valid, 0);
    cycle();
    check("c2_out", {out_valid, out_src, out_data}, {2'b10, 8'h11});
    cycle();
    check("c3_out", {out_valid, out_src, out_data}, {2'b10, 8'h22});
    cycle();
    check("c4_out", {out_valid, out_src, out_data}, {2'b10, 8'h33});
    drain(20, n);
    settle_idle("single");

    // Contention, LOCK_BEATS=1: strict alternation starting with requester 0.
    for (int i = 0; i < 3; i++) begin
      p0_q.push_back(8'hA0 + 8'(i));
      p1_q.push_back(8'hB0 + 8'(i));
      expect_word(1'b0, 8'hA0 + 8'(i));
      expect_word(1'b1, 8'hB0 + 8'(i));
    end
    drain(40, n);
    check("lock1_cycles", n, 8);
    settle_idle("lock1");

    // Contention, LOCK_BEATS=3: source runs of three.
    sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p0_q.push_back(8'hA0 + 8'(i));
      p1_q.push_back(8'hB0 + 8'(i));
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) expect_word(1'b0, 8'hA0 + 8'(3 * g + i));
      for (int i = 0; i < 3; i++) expect_word(1'b1, 8'hB0 + 8'(3 * g + i));
    end
    drain(60, n);
    check("lock3_cycles", n, 14);
    settle_idle("lock3");
    sel = 1'b0;

    // Backpressure: 0x5A held for 4 cycles, then drain and load 0x5B together.
    out_ready = 1'b1;
    p0_q.push_back(8'h5A); p0_q.push_back(8'h5B);
    expect_word(1'b0, 8'h5A); expect_word(1'b0, 8'h5B);
    cycle();
    cycle();
    check("bp_loaded", {out_valid, out_data}, {1'b1, 8'h5A});
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_hold_data", {out_valid, out_src, out_data}, {2'b10, 8'h5A});
      check("bp_hold_readies", {req0_ready, req1_ready}, 0);
      check("bp_hold_state", dbg_state, GRANT0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_next_word", {out_valid, out_src, out_data}, {2'b10, 8'h5B});
    drain(20, n);
    settle_idle("bp");

    // Reset mid-transfer while GRANT1 holds a word; round-robin restarts at 0.
    out_ready = 1'b0;
    p1_q.push_back(8'hC0); p1_q.push_back(8'hC1);
    cycle();
    check("mid_grant1", dbg_state, GRANT1);
    cycle();
    check("mid_held", {out_valid, out_src, out_data}, {2'b11, 8'hC0});
    check("mid_still_grant1", dbg_state, GRANT1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    p1_q.delete();
    p0_q.push_back(8'hD0);
    p1_q.push_back(8'hE0);
    expect_word(1'b0, 8'hD0);
    expect_word(1'b1, 8'hE0);
    cycle();
    check("post_rst_grant", dbg_state, GRANT0);
    drain(20, n);
    settle_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case anything wedges.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shared_stage_arb.md
Name: shared_stage_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared registered datapath stage: input buffer, flop, output buffer.
- Each requester presents data with valid/ready. The block grants one requester at a time, captures the granted word into a single-entry output register, and drives it downstream with valid/ready and a source tag.
- It sits between two producer blocks and one consumer block in the same clock domain. It replaces two private flop stages with one shared stage.

Parameters:
- WIDTH, 8, datapath width in bits.
- LOCK_BEATS, 1, consecutive accepted beats a grant holds before round-robin may switch to the other requester. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle when high together with req0_valid.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle when high together with req1_valid.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered word.
- out_src  out  1  requester index of out_data.
- out_ready  in  1  consumer accepts the word when out_valid is high.
- busy  out  1  high when the FSM is not IDLE or out_valid is high.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, rr_ptr=0 (requester 0 favoured first), beat_cnt=0.
  - out_valid=0, out_data=0, out_src=0, req0_ready=0, req1_ready=0, busy=0.
  - Reset mid-transfer discards the held word and any pending grant; no handshake completes in the reset cycle.
- FSM states: IDLE, GRANT0, GRANT1. Grant is registered, so ready never depends combinationally on the same-cycle valid choice.
- IDLE:
  - Both valid: go to GRANT(rr_ptr).
  - One valid: go to that requester's GRANT state.
  - None valid: stay in IDLE.
- Slot free: slot_free = !out_valid || out_ready.
- In GRANTn: reqn_ready = slot_free. The other requester's ready is 0. Both readies are 0 in IDLE.
- Accept: reqn_valid && reqn_ready.
  - Next edge: out_data<=reqn_data, out_src<=n, out_valid<=1.
  - beat_cnt increments.
- Drain without accept: out_valid && out_ready && no accept. Next edge out_valid<=0.
  - Simultaneous drain and accept gives back-to-back words at full throughput (1 word/cycle).
- Switch rule: evaluated on an accept in GRANTn, with other = 1-n.
  - If beat_cnt+1==LOCK_BEATS and other is valid: go to GRANT(other), rr_ptr<=other, beat_cnt<=0.
  - Else if reqn_valid: stay in GRANTn. If beat_cnt+1==LOCK_BEATS, beat_cnt<=0.
  - Else if other is valid: go to GRANT(other), beat_cnt<=0.
  - Else: go to IDLE, beat_cnt<=0.
- Requester withdrawal: in GRANTn with reqn_valid=0 and no accept, re-arbitrate next edge as in IDLE (other requester first if valid). This requires reqn_valid to drop, which producers must not do once raised (see Protocol).
- Latency: valid rises in IDLE at cycle 0 -> granted in cycle 1 -> accepted in cycle 1 if slot_free -> out_valid=1 in cycle 2.
  - While the grant holds, each further beat adds 1 cycle.
- Backpressure: out_valid && !out_ready holds out_data/out_src stable. reqn_ready=0; the grant and beat_cnt are unchanged.
- beat_cnt width: 4 bits, saturating at LOCK_BEATS-1 then wrapping to 0 on the switch decision.
- Protocol: producers hold valid and data stable until accepted. Consumer ready may toggle freely.

Decomposition:
- Package shared_stage_pkg:
  - arb_state_e enum {IDLE, GRANT0, GRANT1}.
  - src_t (1 bit).
  - BEAT_CNT_W=4.
- Sub-module stage_slot: the single-entry WIDTH+1-bit output register with load/drain/hold logic and the slot_free output.
- The top holds the FSM, rr_ptr, beat_cnt and ready generation.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while req0_valid=1 -> out_valid=0, both readies 0, busy=0. Release -> GRANT0 next cycle, req0_ready=1.
- Single requester, out_ready=1: req0 sends 0x11, 0x22, 0x33 back-to-back -> out_data 0x11/0x22/0x33 on cycles 2/3/4, out_src=0, 1 word/cycle.
- Contention, LOCK_BEATS=1, both always valid with req0 0xA0.., req1 0xB0.. -> output alternates 0xA0, 0xB0, 0xA1, 0xB1, out_src toggling 0,1,0,1.
- Contention, LOCK_BEATS=3 -> out_src pattern 0,0,0,1,1,1,0,0,0.
- Backpressure: out_ready=0 for 4 cycles with out_data=0x5A -> out_data/out_src stable, req0_ready=req1_ready=0. out_ready=1 -> drain and next word 0x5B loaded in the same edge.
- Reset mid-operation: rst_n=0 for 1 cycle while out_valid=1 and in GRANT1 -> out_valid=0, state IDLE, rr_ptr=0. Then both valid -> requester 0 granted first.
